// File: rtl/scm_bist_pkg.sv
// scm_bist_pkg: shared types, March C- element tables and data
// backgrounds for the SCM March BIST controller.
package scm_bist_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  typedef enum logic [2:0] {E0, E1, E2, E3, E4, E5} elem_e;

  // bit 1 = write, bit 0 = data value
  typedef enum logic [1:0] {
    RD0 = 2'b00,
    RD1 = 2'b01,
    WR0 = 2'b10,
    WR1 = 2'b11
  } op_e;

  function automatic logic [1:0] elem_nops(elem_e e);
    logic [1:0] n;
    unique case (e)
      E0, E5:  n = 2'd1;
      default: n = 2'd2;
    endcase
    return n;
  endfunction

  function automatic logic elem_down(elem_e e);
    return (e == E3) || (e == E4);
  endfunction

  function automatic op_e elem_op(elem_e e, logic idx);
    op_e o;
    unique case (e)
      E0:      o = WR0;
      E1, E3:  o = idx ? WR1 : RD0;
      E2, E4:  o = idx ? WR0 : RD1;
      default: o = RD0;
    endcase
    return o;
  endfunction

  function automatic elem_e elem_next(elem_e e);
    elem_e n;
    unique case (e)
      E0:      n = E1;
      E1:      n = E2;
      E2:      n = E3;
      E3:      n = E4;
      E4:      n = E5;
      default: n = E0;
    endcase
    return n;
  endfunction

  function automatic logic op_is_wr(op_e o);
    return o inside {WR0, WR1};
  endfunction

  function automatic logic op_val(op_e o);
    return o inside {RD1, WR1};
  endfunction

  // 2-bit background tile, replicated to the word width by the caller.
  // Pass 1 is a checkerboard that flips on odd addresses.
  function automatic logic [1:0] bg(logic val, logic addr0, logic pass);
    logic [1:0] t;
    t = pass ? (2'b01 ^ {2{addr0}}) : 2'b00;
    return val ? ~t : t;
  endfunction

endpackage

// File: rtl/scm_bist_addr_gen.sv
// scm_bist_addr_gen: loadable up/down address counter for the March
// BIST; last_o flags the final address for the current direction.
module scm_bist_addr_gen #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  load_down_i,
  input  logic                  step_i,
  input  logic                  down_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o
);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  assign addr_o = addr_q;
  assign last_o = down_i ? (addr_q == '0) : (addr_q == '1);

  // load the element start address or step toward its end, never past it
  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_down_i ? '1 : '0;
    end else if (step_i && !last_o) begin
      addr_d = down_i ? addr_q - ADDR_WIDTH'(1)
                      : addr_q + ADDR_WIDTH'(1);
    end
  end

  // address register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) addr_q <= '0;
    else     addr_q <= addr_d;
  end

endmodule

// File: rtl/scm_march_bist_ctrl.sv
// scm_march_bist_ctrl: March C- BIST engine for the latch SCM test port.
// Define SCM_BIST_CHECKERBOARD_EN to append a checkerboard second pass.
module scm_march_bist_ctrl
  import scm_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BYTE   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [DATA_WIDTH-1:0] fail_data_o,
  output logic                  BIST,
  output logic                  CSN_T,
  output logic                  WEN_T,
  output logic [ADDR_WIDTH-1:0] A_T,
  output logic [DATA_WIDTH-1:0] D_T,
  output logic [NUM_BYTE-1:0]   BE_T,
  input  logic [DATA_WIDTH-1:0] Q_T
);

  state_e state_q, state_d;
  elem_e  elem_q, elem_d;
  logic   opi_q, opi_d;
  logic   pass;

  logic                  done_q, done_d;
  logic                  fail_q, fail_d;
  logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
  logic [DATA_WIDTH-1:0] fdata_q, fdata_d;

  logic                  rd_vld_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [DATA_WIDTH-1:0] rd_exp_q;

  logic [ADDR_WIDTH-1:0] addr;
  logic                  addr_last;
  logic                  ag_load, ag_load_down, ag_step;
  op_e                   op;
  logic                  running, op_last, elem_last;
  logic [DATA_WIDTH-1:0] word, syn;

`ifdef SCM_BIST_CHECKERBOARD_EN
  logic pass_q, pass_d;
  assign pass = pass_q;
`else
  assign pass = 1'b0;
`endif

  assign running   = state_q == RUN;
  assign op        = elem_op(elem_q, opi_q);
  assign op_last   = {1'b0, opi_q} == elem_nops(elem_q) - 2'd1;
  assign elem_last = elem_q == E5;
  assign word      = {(DATA_WIDTH/2){bg(op_val(op), addr[0], pass)}};
  assign syn       = rd_exp_q ^ Q_T;

  assign done_o      = done_q;
  assign fail_o      = fail_q;
  assign fail_addr_o = faddr_q;
  assign fail_data_o = fdata_q;

  scm_bist_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ag_load),
    .load_down_i(ag_load_down),
    .step_i     (ag_step),
    .down_i     (elem_down(elem_q)),
    .addr_o     (addr),
    .last_o     (addr_last)
  );

  // state, element and op sequencing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      elem_q  <= E0;
      opi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      opi_q   <= opi_d;
    end
  end

`ifdef SCM_BIST_CHECKERBOARD_EN
  // pass counter: solid pass then checkerboard pass
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pass_q <= 1'b0;
    else     pass_q <= pass_d;
  end
`endif

  // next state: one op per cycle, address steps after the last op
  always_comb begin
    state_d      = state_q;
    elem_d       = elem_q;
    opi_d        = opi_q;
    ag_load      = 1'b0;
    ag_load_down = 1'b0;
    ag_step      = 1'b0;
`ifdef SCM_BIST_CHECKERBOARD_EN
    pass_d       = pass_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d      = RUN;
          elem_d       = E0;
          opi_d        = 1'b0;
          ag_load      = 1'b1;
          ag_load_down = elem_down(E0);
`ifdef SCM_BIST_CHECKERBOARD_EN
          pass_d       = 1'b0;
`endif
        end
      end
      RUN: begin
        if (!op_last) begin
          opi_d = 1'b1;
        end else begin
          opi_d = 1'b0;
          if (!addr_last) begin
            ag_step = 1'b1;
          end else if (!elem_last) begin
            elem_d       = elem_next(elem_q);
            ag_load      = 1'b1;
            ag_load_down = elem_down(elem_d);
          end else begin
`ifdef SCM_BIST_CHECKERBOARD_EN
            if (!pass_q) begin
              pass_d       = 1'b1;
              elem_d       = E0;
              ag_load      = 1'b1;
              ag_load_down = elem_down(E0);
            end else begin
              state_d = DRAIN;
            end
`else
            state_d = DRAIN;
`endif
          end
        end
      end
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // sticky status: cleared on accepted start, first mismatch captured
  always_comb begin
    done_d  = done_q;
    fail_d  = fail_q;
    faddr_d = faddr_q;
    fdata_d = fdata_q;
    if (state_q == IDLE && start_i) begin
      done_d  = 1'b0;
      fail_d  = 1'b0;
      faddr_d = '0;
      fdata_d = '0;
    end
    if (state_q == DRAIN) done_d = 1'b1;
    if (rd_vld_q && (syn != '0) && !fail_q) begin
      fail_d  = 1'b1;
      faddr_d = rd_addr_q;
      fdata_d = syn;
    end
  end

  // status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      faddr_q <= '0;
      fdata_q <= '0;
    end else begin
      done_q  <= done_d;
      fail_q  <= fail_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
    end
  end

  // read pipeline: expectation for the read issued last cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_exp_q  <= '0;
    end else begin
      rd_vld_q  <= running && !op_is_wr(op);
      rd_addr_q <= addr;
      rd_exp_q  <= word;
    end
  end

  // test-port outputs decoded from the state and current op
  always_comb begin
    busy_o = (state_q == RUN) || (state_q == DRAIN);
    BIST   = busy_o;
    CSN_T  = 1'b1;
    WEN_T  = 1'b1;
    A_T    = '0;
    D_T    = '0;
    BE_T   = '0;
    if (running) begin
      CSN_T = 1'b0;
      WEN_T = !op_is_wr(op);
      A_T   = addr;
      D_T   = word;
      BE_T  = '1;
    end
  end

endmodule

// File: tb/tb_scm_march_bist_ctrl.sv
// tb_scm_march_bist_ctrl: scoreboard bench for the March C- BIST engine
// with a fault-injectable SCM model behind the test port.
module tb_scm_march_bist_ctrl;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int N  = 1 << AW;
  localparam int NB = DW / 8;
`ifdef SCM_BIST_CHECKERBOARD_EN
  localparam int P = 2;
`else
  localparam int P = 1;
`endif

  localparam int R0 = 0, R1 = 1, W0 = 2, W1 = 3, NO = -1;
  localparam int MARCH [6][2] = '{'{W0, NO}, '{R0, W1}, '{R1, W0},
                                  '{R0, W1}, '{R1, W0}, '{R0, NO}};

  typedef struct {
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } op_t;

  typedef struct {
    logic          fail;
    logic [AW-1:0] fa;
    logic [DW-1:0] fd;
    int            nrd;
    int            nwr;
  } res_t;

  logic          clk, rst, start_i;
  logic          busy_o, done_o, fail_o, BIST, CSN_T, WEN_T;
  logic [AW-1:0] fail_addr_o, A_T;
  logic [DW-1:0] fail_data_o, D_T, Q_T;
  logic [NB-1:0] BE_T;

  logic [DW-1:0] scm_mem [N];
  int            fk;
  logic [AW-1:0] f_a, f_b;
  int            f_bit;
  logic          f_val;

  op_t  op_q [$];
  res_t res_q [$];
  int   n_checks, n_pass;
  int   busy_cnt, rd_cnt, wr_cnt;
  logic done_prev;

  scm_march_bist_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o),
    .fail_addr_o(fail_addr_o), .fail_data_o(fail_data_o),
    .BIST(BIST), .CSN_T(CSN_T), .WEN_T(WEN_T),
    .A_T(A_T), .D_T(D_T), .BE_T(BE_T), .Q_T(Q_T)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // fault effects: 1 stuck-at, 2 write alias f_a->f_b, 3 coupling
  function automatic logic [DW-1:0] fix_rd(logic [AW-1:0] a,
                                           logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    if (fk == 1 && a == f_a) r[f_bit] = f_val;
    return r;
  endfunction

  function automatic logic [DW-1:0] fix_wr(logic [AW-1:0] a,
                                           logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    if (fk == 3 && a == f_a && d[0] && !d[1]) r[1] = 1'b1;
    return r;
  endfunction

  // SCM behind the wrapper: read data one cycle after the read
  always @(posedge clk) begin
    if (!CSN_T) begin
      if (WEN_T) begin
        Q_T <= fix_rd(A_T, scm_mem[A_T]);
      end else begin
        scm_mem[A_T] <= fix_wr(A_T, D_T);
        if (fk == 2 && A_T == f_a) scm_mem[f_b] <= fix_wr(f_b, D_T);
      end
    end
  end

  function automatic logic [DW-1:0] bgw(int v, logic [AW-1:0] a, int p);
    logic [DW-1:0] w;
    w = (p == 0) ? '0 : ({(DW/2){2'b01}} ^ {DW{a[0]}});
    return (v != 0) ? ~w : w;
  endfunction

  // reference: March C- on an abstract faulty memory
  task automatic model_run();
    logic [DW-1:0] m [N];
    res_t          r;
    op_t           o;
    logic [AW-1:0] a;
    logic [DW-1:0] d, q;
    int            c;
    r = '{default: '0};
    foreach (m[i]) m[i] = '0;
    for (int p = 0; p < P; p++)
      for (int e = 0; e < 6; e++)
        for (int k = 0; k < N; k++) begin
          a = (e == 3 || e == 4) ? AW'(N - 1 - k) : AW'(k);
          for (int j = 0; j < 2; j++) begin
            c = MARCH[e][j];
            if (c == NO) continue;
            d = bgw(c % 2, a, p);
            o.wr = c >= W0;
            o.a  = a;
            o.d  = o.wr ? d : '0;
            op_q.push_back(o);
            if (o.wr) begin
              m[a] = fix_wr(a, d);
              if (fk == 2 && a == f_a) m[f_b] = fix_wr(f_b, d);
              r.nwr++;
            end else begin
              q = fix_rd(a, m[a]);
              r.nrd++;
              if (q !== d && !r.fail) begin
                r.fail = 1'b1;
                r.fa   = a;
                r.fd   = q ^ d;
              end
            end
          end
        end
    res_q.push_back(r);
  endtask

  // monitor: op stream and end-of-run results against the scoreboard
  always @(negedge clk) begin
    op_t           o;
    res_t          r;
    logic [DW-1:0] dd;
    if (rst) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end
    check("bist_busy", 64'(BIST), 64'(busy_o));
    if (!CSN_T) begin
      dd = WEN_T ? '0 : D_T;
      if (op_q.size() == 0) begin
        check("op_extra", 64'(1), 64'(0));
      end else begin
        o = op_q.pop_front();
        check("op", 64'({!WEN_T, A_T, dd, BE_T}),
              64'({o.wr, o.a, o.d, {NB{1'b1}}}));
      end
      if (WEN_T) rd_cnt++;
      else       wr_cnt++;
    end
    if (done_o && !done_prev) begin
      if (res_q.size() == 0) begin
        check("done_extra", 64'(1), 64'(0));
      end else begin
        r = res_q.pop_front();
        check("fail", 64'(fail_o), 64'(r.fail));
        check("fail_addr", 64'(fail_addr_o), 64'(r.fail ? r.fa : '0));
        check("fail_data", 64'(fail_data_o), 64'(r.fail ? r.fd : '0));
        check("busy_cycles", 64'(busy_cnt), 64'(r.nrd + r.nwr + 1));
        check("reads", 64'(rd_cnt), 64'(r.nrd));
        check("writes", 64'(wr_cnt), 64'(r.nwr));
        check("done_idle", 64'({busy_o, BIST, CSN_T}), 64'(3'b001));
      end
      rd_cnt = 0;
      wr_cnt = 0;
    end
    if (busy_o) busy_cnt++;
    else        busy_cnt = 0;
    done_prev = done_o;
  end

  task automatic set_fault(input int k, input logic [AW-1:0] a,
                           input logic [AW-1:0] b, input int bt,
                           input logic v);
    fk    = k;
    f_a   = a;
    f_b   = b;
    f_bit = bt;
    f_val = v;
  endtask

  task automatic launch(input logic hold);
    @(posedge clk);
    #1 start_i = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start_i = 1'b0;
    check("start_busy", 64'({busy_o, BIST}), 64'(2'b11));
    check("start_clr", 64'({done_o, fail_o}), 64'(2'b00));
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done_o && k < 10 * N * P + 40) begin
      @(negedge clk);
      k++;
    end
    check("done_timeout", 64'(done_o), 64'(1));
  endtask

  initial begin
    int k;
    n_checks  = 0;
    n_pass    = 0;
    busy_cnt  = 0;
    rd_cnt    = 0;
    wr_cnt    = 0;
    done_prev = 1'b0;
    rst       = 1'b1;
    start_i   = 1'b0;
    set_fault(0, '0, '0, 0, 1'b0);
    #1;
    check("rst_flags", 64'({busy_o, done_o, fail_o, BIST}), 64'(0));
    check("rst_port", 64'({CSN_T, WEN_T}), 64'(2'b11));
    check("rst_bus", 64'({A_T, D_T, BE_T}), 64'(0));
    check("rst_fail", 64'({fail_addr_o, fail_data_o}), 64'(0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    model_run();
    launch(1'b0);
    wait_done();

    set_fault(1, 5'h0A, '0, 7, 1'b1);
    model_run();
    launch(1'b0);
    wait_done();

    set_fault(2, 5'h03, 5'h13, 0, 1'b0);
    model_run();
    launch(1'b0);
    wait_done();

    set_fault(1, 5'h0A, '0, 7, 1'b1);
    model_run();
    launch(1'b0);
    repeat (99) @(posedge clk);
    #1 check("pre_rst_fail", 64'(fail_o), 64'(1));
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst", 64'({BIST, CSN_T, busy_o, fail_o, done_o}),
          64'(5'b01000));
    op_q.delete();
    res_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    set_fault(0, '0, '0, 0, 1'b0);
    model_run();
    launch(1'b0);
    wait_done();

    set_fault(1, AW'($urandom), '0, int'($urandom_range(0, DW - 1)), 1'b0);
    model_run();
    launch(1'b0);
    repeat (49) @(posedge clk);
    #1 start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (149) @(posedge clk);
    #1 start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    wait_done();
    set_fault(0, '0, '0, 0, 1'b0);
    model_run();
    launch(1'b0);
    wait_done();

    model_run();
    model_run();
    launch(1'b1);
    wait_done();
    k = 0;
    while (!busy_o && k < 8) begin
      @(posedge clk);
      #1 k++;
    end
    check("restart", 64'({busy_o, done_o, fail_o}), 64'(3'b100));
    start_i = 1'b0;
    wait_done();

    set_fault(3, 5'h04, '0, 0, 1'b0);
    model_run();
    launch(1'b0);
    wait_done();

    for (int i = 0; i < 4; i++) begin
      logic [AW-1:0] ra;
      ra = AW'($urandom);
      set_fault(int'($urandom_range(0, 3)), ra,
                ra ^ AW'($urandom_range(1, N - 1)),
                int'($urandom_range(0, DW - 1)), 1'($urandom));
      model_run();
      launch(1'b0);
      wait_done();
    end

    @(negedge clk);
    check("queues_empty", 64'(op_q.size() + res_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
